// File: rtl/rv_fetch_icache_pkg.sv
// Shared pipeline package: bubble encoding, RV32I major opcodes, fetch FSM
// state type and a word-alignment helper.
// No ports (package).
package rv_pipe_pkg;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    FILL         = 2'd1,
    FILL_DISCARD = 2'd2
  } fetch_state_t;

  // Force an address onto a 32-bit word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv_fetch_icache_if.sv
// Refill bus between the fetch stage (master) and backing memory (slave).
// Signals:
//   mem_req   master->slave  refill request, held until acknowledged
//   mem_addr  master->slave  word-aligned refill address
//   mem_ack   slave->master  mem_rdata valid, completes the request
//   mem_rdata slave->master  refill word
interface rv_fetch_icache_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/rv_fetch_icache_array.sv
// icache_array: direct-mapped storage, one 32-bit word per line.
// Ports:
//   clock, reset              clock and asynchronous active-high reset
//   rd_idx, rd_tag            combinational lookup address
//   rd_hit, rd_data           lookup result (valid and tag match, line data)
//   wr_en, wr_idx, wr_tag,
//   wr_data                   line write, sets the line valid
//   inval_all                 clear every valid bit at the edge
module icache_array #(
  parameter int LINES = 4,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic             inval_all
);

  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [31:0]      data_r [LINES];

  // Valid bits: invalidate-all wins over a same-edge write so a discarded
  // refill can never leave a live line behind.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r <= {LINES{1'b0}};
    end else if (inval_all) begin
      valid_r <= {LINES{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data payload; contents are meaningless until the valid bit is set.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_r[wr_idx]  <= wr_tag;
      data_r[wr_idx] <= wr_data;
    end
  end

  assign rd_hit  = valid_r[rd_idx] && (tag_r[rd_idx] == rd_tag);
  assign rd_data = data_r[rd_idx];

endmodule

// File: rtl/rv_fetch_icache.sv
// rv_fetch_icache: instruction fetch stage with a direct-mapped I-cache and a
// req/ack refill port. Owns the PC, delivers one instruction per cycle on hits.
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   redirect_valid, redirect_pc  taken branch/jump target (bits [1:0] ignored)
//   stall                        hold outputs and PC, no lookup
//   invalidate_all               clear all cache valid bits (fence.i)
//   out_valid, out_pc, out_instr registered instruction to decode
//   mem                          refill bus (master side)
//   hit_count, miss_count        lookup statistics, wrap modulo 2^32
module rv_fetch_icache
  import rv_pipe_pkg::*;
#(
  parameter int          LINES    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     stall,
  input  logic                     invalidate_all,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  rv_fetch_icache_if.master        mem,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic [31:0]  fill_addr_r;
  logic         mem_req_r;
  logic [31:0]  mem_addr_r;

  logic             hit_s;
  logic [31:0]      line_data_s;
  logic             wr_en_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic [TAG_W-1:0] rd_tag_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [TAG_W-1:0] wr_tag_s;

  assign rd_idx_s = pc_r[2+IDX_W-1:2];
  assign rd_tag_s = pc_r[31:2+IDX_W];
  assign wr_idx_s = fill_addr_r[2+IDX_W-1:2];
  assign wr_tag_s = fill_addr_r[31:2+IDX_W];

  // An invalidate landing on the ack edge discards the returning word.
  assign wr_en_s = (state_r == FILL) && mem.mem_ack && !invalidate_all;

  assign mem.mem_req  = mem_req_r;
  assign mem.mem_addr = mem_addr_r;

  icache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .rd_idx    (rd_idx_s),
    .rd_tag    (rd_tag_s),
    .rd_hit    (hit_s),
    .rd_data   (line_data_s),
    .wr_en     (wr_en_s),
    .wr_idx    (wr_idx_s),
    .wr_tag    (wr_tag_s),
    .wr_data   (mem.mem_rdata),
    .inval_all (invalidate_all)
  );

  // Fetch FSM: PC, registered outputs, refill request and statistics.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= RUN;
      pc_r        <= RESET_PC;
      fill_addr_r <= 32'h0000_0000;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      out_valid   <= 1'b0;
      out_pc      <= 32'h0000_0000;
      out_instr   <= BUBBLE_INSTR;
      hit_count   <= 32'h0000_0000;
      miss_count  <= 32'h0000_0000;
    end else begin
      case (state_r)
        RUN: begin
          if (redirect_valid) begin
            pc_r      <= word_align(redirect_pc);
            out_valid <= 1'b0;
            out_pc    <= 32'h0000_0000;
            out_instr <= BUBBLE_INSTR;
          end else if (stall) begin
            pc_r      <= pc_r;
            out_valid <= out_valid;
          end else if (hit_s) begin
            out_valid <= 1'b1;
            out_pc    <= pc_r;
            out_instr <= line_data_s;
            pc_r      <= pc_r + 32'd4;
            hit_count <= hit_count + 32'd1;
          end else begin
            out_valid   <= 1'b0;
            out_pc      <= 32'h0000_0000;
            out_instr   <= BUBBLE_INSTR;
            mem_req_r   <= 1'b1;
            mem_addr_r  <= pc_r;
            fill_addr_r <= pc_r;
            miss_count  <= miss_count + 32'd1;
            state_r     <= FILL;
          end
        end
        FILL: begin
          // Redirects only retarget the PC; the refill always runs to completion.
          if (redirect_valid) begin
            pc_r <= word_align(redirect_pc);
          end
          if (mem.mem_ack) begin
            mem_req_r <= 1'b0;
            state_r   <= RUN;
          end else if (invalidate_all) begin
            state_r <= FILL_DISCARD;
          end else begin
            state_r <= FILL;
          end
        end
        FILL_DISCARD: begin
          if (redirect_valid) begin
            pc_r <= word_align(redirect_pc);
          end
          if (mem.mem_ack) begin
            mem_req_r <= 1'b0;
            state_r   <= RUN;
          end else begin
            state_r <= FILL_DISCARD;
          end
        end
        default: begin
          state_r   <= RUN;
          mem_req_r <= 1'b0;
          out_valid <= 1'b0;
          out_instr <= BUBBLE_INSTR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_fetch_icache.sv
// Self-checking bench for rv_fetch_icache (LINES=4, RESET_PC=0) with a
// two-cycle-latency backing memory and an in-order output scoreboard.
module tb_rv_fetch_icache;
  import rv_pipe_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        invalidate_all;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q [$];
  logic        stall_seen = 1'b0;
  int          ack_cnt = 0;

  rv_fetch_icache_if mif ();

  rv_fetch_icache #(.LINES(4), .RESET_PC(32'h0000_0000)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .invalidate_all (invalidate_all),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .mem            (mif),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    return {a[23:0], 8'h13};
  endfunction

  // Backing memory: ack sampled at the second edge after req is first seen.
  always @(negedge clock) begin
    if (reset) begin
      ack_cnt = 0;
      mif.mem_ack = 1'b0;
      mif.mem_rdata = 32'h0000_0000;
    end else if (mif.mem_ack) begin
      mif.mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mif.mem_req) begin
      ack_cnt = ack_cnt + 1;
      if (ack_cnt >= 2) begin
        mif.mem_ack = 1'b1;
        mif.mem_rdata = mem_word(mif.mem_addr);
      end
    end else begin
      ack_cnt = 0;
    end
  end

  always @(posedge clock) stall_seen <= stall;

  // Scoreboard: every fresh valid output must match the head of the queue.
  always @(negedge clock) begin
    logic [63:0] e;
    if (!reset) begin
      if (out_valid && !stall_seen) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got pc=%h instr=%h, required no output", out_pc, out_instr);
        end else begin
          e = exp_q.pop_front();
          if ({out_pc, out_instr} !== e) begin
            bad++;
            $display("FAIL out_data: got pc=%h instr=%h, required pc=%h instr=%h",
                     out_pc, out_instr, e[63:32], e[31:0]);
          end
        end
      end
      if (!out_valid) begin
        total++;
        if (out_instr !== BUBBLE_INSTR) begin
          bad++;
          $display("FAIL bubble: got instr=%h, required %h", out_instr, BUBBLE_INSTR);
        end
      end
    end
  end

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic wait_pc(input logic [31:0] pc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_valid && out_pc == pc) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    stall = 1'b0; invalidate_all = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if ({out_valid, out_pc, out_instr} !== {1'b0, 32'h0, BUBBLE_INSTR}) begin
      bad++; $display("FAIL reset_out: got %b %h %h, required 0 0 %h", out_valid, out_pc, out_instr, BUBBLE_INSTR);
    end
    total++;
    if ({mif.mem_req, mif.mem_addr} !== {1'b0, 32'h0}) begin
      bad++; $display("FAIL reset_mem: got req=%b addr=%h, required 0 0", mif.mem_req, mif.mem_addr);
    end
    total++;
    if ({hit_count, miss_count} !== 64'h0) begin
      bad++; $display("FAIL reset_cnt: got hit=%0d miss=%0d, required 0 0", hit_count, miss_count);
    end
  endtask

  task automatic test_cold_start();
    bit ok;
    expect_pc(32'h0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      total++;
      if ({mif.mem_req, mif.mem_addr} !== {1'b1, 32'h0}) begin
        bad++; $display("FAIL cold_req%0d: got req=%b addr=%h, required 1 0", i, mif.mem_req, mif.mem_addr);
      end
    end
    @(negedge clock);
    total++;
    if ({mif.mem_req, out_valid} !== 2'b00) begin
      bad++; $display("FAIL cold_ack: got req=%b valid=%b, required 0 0", mif.mem_req, out_valid);
    end
    @(negedge clock);
    total++;
    if ({out_valid, miss_count, hit_count} !== {1'b1, 32'd1, 32'd1}) begin
      bad++; $display("FAIL cold_first: got valid=%b miss=%0d hit=%0d, required 1 1 1", out_valid, miss_count, hit_count);
    end
    expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    wait_pc(32'hC, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL cold_reach_c: got timeout, required pc 0xc");
    end
  endtask

  task automatic test_warm_loop();
    logic [31:0] h0;
    h0 = hit_count;
    total++;
    if (h0 !== 32'd4) begin
      bad++; $display("FAIL warm_hits_before: got %0d, required 4", h0);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0003;
    @(negedge clock);
    redirect_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL warm_squash: got valid=%b, required 0", out_valid);
    end
    for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++;
      if ({out_valid, mif.mem_req, out_pc} !== {1'b1, 1'b0, 32'(i * 4)}) begin
        bad++; $display("FAIL warm_seq%0d: got valid=%b req=%b pc=%h, required 1 0 %h", i, out_valid, mif.mem_req, out_pc, i * 4);
      end
    end
    total++;
    if (hit_count - h0 !== 32'd4) begin
      bad++; $display("FAIL warm_hits_delta: got %0d, required 4", hit_count - h0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] m0;
    bit ok;
    m0 = miss_count;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if ({out_valid, out_pc, out_instr, mif.mem_req} !== {1'b1, 32'hC, mem_word(32'hC), 1'b0}) begin
        bad++; $display("FAIL stall_hold%0d: got valid=%b pc=%h instr=%h req=%b, required 1 c %h 0",
                        i, out_valid, out_pc, out_instr, mif.mem_req, mem_word(32'hC));
      end
    end
    stall = 1'b0;
    @(negedge clock);
    total++;
    if ({mif.mem_req, mif.mem_addr, miss_count} !== {1'b1, 32'h10, m0 + 32'd1}) begin
      bad++; $display("FAIL stall_resume: got req=%b addr=%h miss=%0d, required 1 10 %0d", mif.mem_req, mif.mem_addr, miss_count, m0 + 1);
    end
    expect_pc(32'h10);
    wait_pc(32'h10, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL stall_reach_10: got timeout, required pc 0x10");
    end
  endtask

  task automatic test_aliasing();
    logic [31:0] m0;
    bit ok;
    m0 = miss_count;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    @(negedge clock);
    redirect_valid = 1'b0;
    @(negedge clock);
    total++;
    if ({mif.mem_req, mif.mem_addr, miss_count} !== {1'b1, 32'h0, m0 + 32'd1}) begin
      bad++; $display("FAIL alias_miss: got req=%b addr=%h miss=%0d, required 1 0 %0d", mif.mem_req, mif.mem_addr, miss_count, m0 + 1);
    end
    expect_pc(32'h0);
    wait_pc(32'h0, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL alias_reach_0: got timeout, required pc 0x0");
    end
  endtask

  task automatic test_redirect_fill();
    bit ok;
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    @(negedge clock);
    redirect_valid = 1'b0;
    @(negedge clock);
    total++;
    if ({mif.mem_req, mif.mem_addr} !== {1'b1, 32'h20}) begin
      bad++; $display("FAIL rfill_req: got req=%b addr=%h, required 1 20", mif.mem_req, mif.mem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clock);
    redirect_valid = 1'b0;
    total++;
    if ({mif.mem_req, mif.mem_addr} !== {1'b1, 32'h20}) begin
      bad++; $display("FAIL rfill_stable: got req=%b addr=%h, required 1 20", mif.mem_req, mif.mem_addr);
    end
    @(negedge clock);
    total++;
    if (mif.mem_req !== 1'b0) begin
      bad++; $display("FAIL rfill_done: got req=%b, required 0", mif.mem_req);
    end
    @(negedge clock);
    total++;
    if ({mif.mem_req, mif.mem_addr} !== {1'b1, 32'h40}) begin
      bad++; $display("FAIL rfill_new: got req=%b addr=%h, required 1 40", mif.mem_req, mif.mem_addr);
    end
    expect_pc(32'h40);
    wait_pc(32'h40, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rfill_reach_40: got timeout, required pc 0x40");
    end
  endtask

  task automatic test_invalidate(input bit same_cycle, input logic [31:0] pc);
    logic [31:0] m0;
    bit ok;
    m0 = miss_count;
    @(negedge clock);
    total++;
    if ({mif.mem_req, mif.mem_addr} !== {1'b1, pc}) begin
      bad++; $display("FAIL inval%0d_req1: got req=%b addr=%h, required 1 %h", same_cycle, mif.mem_req, mif.mem_addr, pc);
    end
    invalidate_all = !same_cycle;
    @(negedge clock);
    invalidate_all = same_cycle;
    @(negedge clock);
    invalidate_all = 1'b0;
    total++;
    if (mif.mem_req !== 1'b0) begin
      bad++; $display("FAIL inval%0d_drop: got req=%b, required 0", same_cycle, mif.mem_req);
    end
    @(negedge clock);
    total++;
    if ({mif.mem_req, mif.mem_addr, miss_count} !== {1'b1, pc, m0 + 32'd2}) begin
      bad++; $display("FAIL inval%0d_req2: got req=%b addr=%h miss=%0d, required 1 %h %0d",
                      same_cycle, mif.mem_req, mif.mem_addr, miss_count, pc, m0 + 2);
    end
    expect_pc(pc);
    wait_pc(pc, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL inval%0d_reach: got timeout, required pc %h", same_cycle, pc);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit ok;
    @(negedge clock);
    total++;
    if (mif.mem_req !== 1'b1) begin
      bad++; $display("FAIL rst_pre_req: got req=%b, required 1", mif.mem_req);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({mif.mem_req, out_valid, hit_count, miss_count} !== {2'b00, 64'h0}) begin
      bad++; $display("FAIL rst_mid: got req=%b valid=%b hit=%0d miss=%0d, required 0 0 0 0",
                      mif.mem_req, out_valid, hit_count, miss_count);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++;
    if ({mif.mem_req, mif.mem_addr} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL rst_refetch: got req=%b addr=%h, required 1 0", mif.mem_req, mif.mem_addr);
    end
    expect_pc(32'h0);
    wait_pc(32'h0, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rst_reach_0: got timeout, required pc 0x0");
    end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_warm_loop();
    test_stall();
    test_aliasing();
    test_redirect_fill();
    test_invalidate(1'b0, 32'h44);
    test_invalidate(1'b1, 32'h48);
    test_reset_mid_fill();
    @(negedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
